// File: rtl/shift_ctrl_pkg.sv
// Shared definitions for the shift sequencer: mode and state encodings,
// the default amount width, and the fill-bit selection helper.
package shift_ctrl_pkg;

   localparam int AMT_W_DEF = 5;

   localparam logic [1:0] SH_LSR = 2'b00;
   localparam logic [1:0] SH_ASR = 2'b01;
   localparam logic [1:0] SH_ROR = 2'b10;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_t;

   // Bit entering at position 31 on a right shift; mode 11 falls back to logical.
   function automatic logic fill_bit(input logic [1:0] mode, input logic msb, input logic lsb);
      logic f;
      case (mode)
         SH_ASR:  f = msb;
         SH_ROR:  f = lsb;
         default: f = 1'b0;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/shift_right_reg32.sv
// 32-bit loadable right-shift register: parallel load when sr=0, one-bit
// right shift with srin entering at bit 31 when sr=1; holds when we=0.
module shift_right_reg32 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] d,
   input  logic        we,
   input  logic        sr,
   input  logic        srin,
   output logic [31:0] q
);

   logic [31:0] q_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q_q <= '0;
      end else if (we) begin
         q_q <= sr ? {srin, q_q[31:1]} : d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/shift_seq_ctrl32.sv
// Multi-bit shift/rotate sequencer: loads an operand, steps the shift register
// one bit per clock for the requested amount, then pulses done for one cycle.
module shift_seq_ctrl32
   import shift_ctrl_pkg::*;
#(
   parameter int AMT_W = AMT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [31:0]      din,
   input  logic [AMT_W-1:0] amt,
   input  logic [1:0]       mode,
   output logic             busy,
   output logic             done,
   output logic [31:0]      dout,
   output logic             carry
);

   state_t           state_q, state_d;
   logic [AMT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       mode_q, mode_d;
   logic             carry_q, carry_d;

   logic             rst_n;
   logic             we, sr, srin;
   logic             done_d;
   logic [31:0]      q;

   // Datapath reset is derived in the same clock domain, so it clears on the same edge.
   assign rst_n = ~rst;

   shift_right_reg32 u_sreg (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (din),
      .we    (we),
      .sr    (sr),
      .srin  (srin),
      .q     (q)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         mode_q  <= SH_LSR;
         carry_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         carry_q <= carry_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      carry_d = carry_q;
      we      = 1'b0;
      sr      = 1'b0;
      srin    = fill_bit(mode_q, q[31], q[0]);
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               we      = 1'b1;
               mode_d  = mode;
               cnt_d   = amt;
               carry_d = 1'b0;
               state_d = (amt == '0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            we      = 1'b1;
            sr      = 1'b1;
            carry_d = q[0];
            cnt_d   = cnt_q - AMT_W'(1);
            if (cnt_q == AMT_W'(1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy  = (state_q != IDLE);
   assign done  = done_d;
   assign dout  = q;
   assign carry = carry_q;

endmodule

// File: tb/tb_shift_seq_ctrl32.sv
// Directed bench for shift_seq_ctrl32: shift modes, zero and full amounts,
// busy/done timing, ignored start, mid-command reset and reset/start collision.
module tb_shift_seq_ctrl32;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] din;
   logic [4:0]  amt;
   logic [1:0]  mode;
   logic        busy;
   logic        done;
   logic [31:0] dout;
   logic        carry;

   int checks = 0;
   int errors = 0;

   shift_seq_ctrl32 #(.AMT_W(5)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .din   (din),
      .amt   (amt),
      .mode  (mode),
      .busy  (busy),
      .done  (done),
      .dout  (dout),
      .carry (carry)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one command from IDLE and follow it to completion.
   // lat counts rising edges from the accepting edge up to the one after which
   // done is seen; busy_n counts sampled busy cycles (DONE included).
   task automatic run_cmd(input logic [31:0] d, input logic [4:0] a, input logic [1:0] m,
                          input logic [31:0] exp_dout, input logic exp_carry,
                          input int exp_lat, input int exp_busy, input string tag);
      int lat;
      int busy_n;
      din   = d;
      amt   = a;
      mode  = m;
      start = 1'b1;
      step();
      start  = 1'b0;
      din    = 32'h0BAD_0BAD;
      lat    = 1;
      busy_n = 0;
      while (lat < 100) begin
         if (busy) busy_n++;
         if (done) break;
         step();
         lat++;
      end
      check_val({tag, "_lat"},   lat,       exp_lat);
      check_val({tag, "_busy"},  busy_n,    exp_busy);
      check_val({tag, "_dout"},  dout,      exp_dout);
      check_val({tag, "_carry"}, carry,     exp_carry);
      step();
      check_val({tag, "_done1"}, done,      1'b0);
      check_val({tag, "_idle"},  busy,      1'b0);
      check_val({tag, "_hold"},  dout,      exp_dout);
      check_val({tag, "_holdc"}, carry,     exp_carry);
   endtask

   initial begin
      int done_n;
      rst   = 1'b1;
      start = 1'b0;
      din   = '0;
      amt   = '0;
      mode  = 2'b00;
      repeat (3) step();
      check_val("rst_busy",  busy,  1'b0);
      check_val("rst_done",  done,  1'b0);
      check_val("rst_dout",  dout,  32'h0);
      check_val("rst_carry", carry, 1'b0);
      rst = 1'b0;
      step();

      run_cmd(32'h8000_0001, 5'd4,  2'b00, 32'h0800_0000, 1'b0, 5,  5,  "lsr");
      run_cmd(32'h8000_0010, 5'd4,  2'b01, 32'hF800_0001, 1'b0, 5,  5,  "asr");
      run_cmd(32'h8000_0000, 5'd31, 2'b01, 32'hFFFF_FFFF, 1'b0, 32, 32, "asr31");
      run_cmd(32'h0000_0001, 5'd1,  2'b10, 32'h8000_0000, 1'b1, 2,  2,  "ror");
      // Follows a carry=1 result, so this also shows carry is cleared on load.
      run_cmd(32'h1234_5678, 5'd0,  2'b00, 32'h1234_5678, 1'b0, 1,  1,  "zero");
      run_cmd(32'h8000_0001, 5'd4,  2'b11, 32'h0800_0000, 1'b0, 5,  5,  "mode11");

      // Long command, a second start while busy, then reset mid-command.
      din   = 32'hF0F0_F0FF;
      amt   = 5'd20;
      mode  = 2'b00;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      din   = 32'h1234_5678;
      start = 1'b1;
      step();
      start = 1'b0;
      check_val("ign_dout",  dout,  32'h1E1E_1E1F);
      check_val("ign_carry", carry, 1'b1);
      check_val("ign_busy",  busy,  1'b1);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_val("abort_busy",  busy,  1'b0);
      check_val("abort_dout",  dout,  32'h0);
      check_val("abort_carry", carry, 1'b0);
      done_n = 0;
      repeat (30) begin
         if (done) done_n++;
         step();
      end
      check_val("abort_nodone", done_n, 0);

      run_cmd(32'hA5A5_A5A5, 5'd3, 2'b10, 32'hB4B4_B4B4, 1'b1, 4, 4, "post_rst");

      // Reset and start in the same cycle: the command must be dropped.
      din   = 32'hDEAD_BEEF;
      amt   = 5'd2;
      mode  = 2'b00;
      start = 1'b1;
      rst   = 1'b1;
      step();
      start = 1'b0;
      rst   = 1'b0;
      check_val("coll_busy",  busy,  1'b0);
      check_val("coll_dout",  dout,  32'h0);
      check_val("coll_carry", carry, 1'b0);
      step();
      check_val("coll_busy2", busy,  1'b0);
      check_val("coll_done",  done,  1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
